request_conditioner: RTL and testbench
======================================

Name: request_conditioner

Overview:
- Upstream front-end for the traffic controller. Conditions four raw pedestrian/vehicle push-buttons (north, south, east, west) into the single level `request` that the controller consumes to stretch green phases from 10 to 15 cycles.
- Per button: synchronises, debounces and latches presses, holding each as pending until the controller serves that axis.
- Flags a demand that stays unserved too long.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed to accept a press or release; legal range 1..255.
- MAX_PENDING, 64: consecutive cycles `request` may stay high before `stuck_alarm` sets; legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- btn_raw  input  4  asynchronous raw buttons, index 0=N, 1=S, 2=E, 3=W; active-high, may bounce.
- ns_green  input  1  controller north_green (north and south green together).
- ew_green  input  1  controller east_green (east and west green together).
- request  output  1  OR of pending bits, to controller `request`.
- pending  output  4  latched unserved demand per direction.
- stuck_alarm  output  1  sticky: demand unserved for MAX_PENDING cycles.

Behaviour:
- Reset (rst high at an edge):
  - Synchroniser flops, debouncer state/counters, pending, the green-delay flops, the pending-age counter and stuck_alarm all go to 0.
  - request=0. All outputs are registered or derived from registers.
  - Reset mid-debounce or mid-pending discards everything; no event is remembered.
- Synchroniser: 2 flops per bit, reset to 0.
- Debouncer (one per bit), states IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE:
  - IDLE: a sync sample of 1 goes to CONFIRM_PRESS with cnt=1.
  - CONFIRM_PRESS: each 1 sample does cnt+1. When cnt reaches DEBOUNCE_CYCLES, go to PRESSED and emit a 1-cycle press_pulse. Any 0 sample returns to IDLE with cnt=0.
  - PRESSED: a 0 sample goes to CONFIRM_RELEASE with cnt=1.
  - CONFIRM_RELEASE: DEBOUNCE_CYCLES consecutive 0 samples go to IDLE. A 1 sample returns to PRESSED with no pulse.
  - Holding a button gives exactly one pulse.
  - With DEBOUNCE_CYCLES=1, the state goes from IDLE directly to PRESSED, with the pulse, on the first 1 sample.
- Latency: with btn_raw stable high, pending[d] is 1 after the (DEBOUNCE_CYCLES+3)-th rising edge that samples btn_raw[d] high. The first sampling edge counts as 1.
- Service clear:
  - ns_green and ew_green are registered once (ns_d, ew_d).
  - Falling edge ns_d & ~ns_green clears pending[0] and pending[1] at the next edge.
  - Falling edge ew_d & ~ew_green clears pending[2] and pending[3] at the next edge.
- Simultaneous press_pulse and clear for the same bit: set wins; the bit stays 1 and is served at that axis's next green end.
- Presses on already-pending bits: no effect.
- request = |pending (combinational OR of registers).
- Age counter:
  - Increments, saturating, each cycle request=1; resets to 0 on any cycle request=0.
  - When it reaches MAX_PENDING-1 while request=1, stuck_alarm goes to 1 at that edge and stays there until rst.
  - Width is $clog2(MAX_PENDING+1).
- Inputs ns_green and ew_green are synchronous to clk; no synchroniser.

Decomposition:
- Package traffic_pkg:
  - direction index constants DIR_N=0, DIR_S=1, DIR_E=2, DIR_W=3, NUM_DIRS=4.
  - debouncer state enum (IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE).
  - axis masks NS_MASK=4'b0011, EW_MASK=4'b1100.
- One sub-module, `button_debouncer` (synchroniser + debounce FSM + press_pulse, parameter DEBOUNCE_CYCLES), instantiated NUM_DIRS times by generate.
- Top holds pending, the clear logic, the age counter and the alarm.

Test Plan (DEBOUNCE_CYCLES=4, MAX_PENDING=16):
1. Reset, then btn_raw=0000 for 20 cycles -> request=0, pending=0000, stuck_alarm=0 throughout.
2. btn_raw[0] high from edge 1, held -> pending=0001 and request=1 after edge 7, not before. Hold 30 cycles -> still a single set; no re-trigger after release and re-press within 3 cycles.
3. Bounce: btn_raw[2] toggles 1,1,0,1,1,1,0 -> pending stays 0000. Then stable high for 7 edges -> pending=0100.
4. pending=0011, ns_green 1 for 10 cycles then 0 -> pending=0000 one edge after the falling edge, request drops. ew_green falling in the same window leaves N/S bits untouched.
5. press_pulse for bit 1 in the same cycle as the NS clear -> pending[1]=1 afterward; pending[0]=0.
6. pending=1000 with no ew_green activity -> stuck_alarm=1 at the 15th edge with request high. Clearing pending leaves stuck_alarm=1. rst=1 for one edge -> all outputs 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic request front-end.
// Direction indices, axis masks and the debouncer state encoding.
package traffic_pkg;

    localparam int DIR_N    = 0;
    localparam int DIR_S    = 1;
    localparam int DIR_E    = 2;
    localparam int DIR_W    = 3;
    localparam int NUM_DIRS = 4;

    localparam logic [NUM_DIRS-1:0] NS_MASK = 4'b0011;
    localparam logic [NUM_DIRS-1:0] EW_MASK = 4'b1100;

    typedef enum logic [1:0] {
        IDLE            = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } deb_state_e;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, debounce FSM, registered 1-cycle press pulse.
// Pulse appears DEBOUNCE_CYCLES+2 edges after the first high sample; no backpressure.
module button_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES);

    logic [1:0]  sync_ff;
    logic        sample;
    deb_state_e  state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        pulse_nxt;

    assign sample = sync_ff[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff     <= 2'b00;
            state       <= IDLE;
            cnt         <= 8'd0;
            press_pulse <= 1'b0;
        end else begin
            sync_ff     <= {sync_ff[0], btn_raw};
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            press_pulse <= pulse_nxt;
        end
    end

    // cnt holds the number of consecutive confirming samples already seen
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sample) begin
                    if (CNT_LAST == 8'd1) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = 8'd0;
                        pulse_nxt = 1'b1;
                    end else begin
                        state_nxt = CONFIRM_PRESS;
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            CONFIRM_PRESS: begin
                if (!sample) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else if (cnt + 8'd1 == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = 8'd0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            PRESSED: begin
                if (!sample) begin
                    if (CNT_LAST == 8'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 8'd0;
                    end else begin
                        state_nxt = CONFIRM_RELEASE;
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            CONFIRM_RELEASE: begin
                if (sample) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = 8'd0;
                end else if (cnt + 8'd1 == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/request_conditioner.sv
// Turns four raw buttons into latched per-direction demand, cleared at the end of that axis's green.
// pending sets DEBOUNCE_CYCLES+3 edges after a stable press; no backpressure, stuck_alarm is sticky.
module request_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_PENDING     = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_DIRS-1:0] btn_raw,
    input  logic                ns_green,
    input  logic                ew_green,
    output logic                request,
    output logic [NUM_DIRS-1:0] pending,
    output logic                stuck_alarm
);

    localparam int               AGE_W     = $clog2(MAX_PENDING + 1);
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_PENDING - 1);

    logic [NUM_DIRS-1:0] press;
    logic [NUM_DIRS-1:0] clear_mask;
    logic                ns_d, ew_d;
    logic                ns_fall, ew_fall;
    logic [AGE_W-1:0]    age, age_nxt;

    for (genvar g = 0; g < NUM_DIRS; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (btn_raw[g]),
            .press_pulse (press[g])
        );
    end

    assign ns_fall    = ns_d & ~ns_green;
    assign ew_fall    = ew_d & ~ew_green;
    assign clear_mask = ({NUM_DIRS{ns_fall}} & NS_MASK) | ({NUM_DIRS{ew_fall}} & EW_MASK);
    assign request    = |pending;
    assign age_nxt    = (age == {AGE_W{1'b1}}) ? age : age + AGE_W'(1);

    // A press arriving with its axis clear is kept: it waits for the next green end.
    always_ff @(posedge clk) begin
        if (rst) begin
            ns_d    <= 1'b0;
            ew_d    <= 1'b0;
            pending <= '0;
        end else begin
            ns_d    <= ns_green;
            ew_d    <= ew_green;
            pending <= (pending & ~clear_mask) | press;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age         <= '0;
            stuck_alarm <= 1'b0;
        end else if (request) begin
            age <= age_nxt;
            if (age_nxt == AGE_LIMIT) begin
                stuck_alarm <= 1'b1;
            end
        end else begin
            age <= '0;
        end
    end

endmodule

// File: tb/tb_request_conditioner.sv
// Directed stimulus with a scoreboard queue; a negedge monitor pops and compares every cycle.
module tb_request_conditioner;
    import traffic_pkg::*;

    localparam int DB  = 4;
    localparam int MAXP = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       ns_green;
    logic       ew_green;
    logic       request;
    logic [3:0] pending;
    logic       stuck_alarm;

    typedef struct packed {
        logic [3:0] p;
        logic       r;
        logic       a;
        int         step;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    step_no = 0;
    int    run = 0;
    logic  m_req = 1'b0;
    logic  m_alarm = 1'b0;
    string phase = "reset";

    request_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .MAX_PENDING     (MAXP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .ns_green    (ns_green),
        .ew_green    (ew_green),
        .request     (request),
        .pending     (pending),
        .stuck_alarm (stuck_alarm)
    );

    always #5 clk = ~clk;

    // Advance one edge; exp_p is the hand-derived pending value after it.
    // The alarm expectation follows the age rule: set on the (MAXP-1)-th consecutive edge with request high.
    task automatic tick(input logic [3:0] exp_p);
        exp_t e;
        @(posedge clk);
        if (rst) begin
            run     = 0;
            m_alarm = 1'b0;
        end else begin
            if (m_req) run++;
            else run = 0;
            if (run >= MAXP - 1) m_alarm = 1'b1;
        end
        m_req = |exp_p;
        #1;
        step_no++;
        e.p    = exp_p;
        e.r    = m_req;
        e.a    = m_alarm;
        e.step = step_no;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 3;
            if (pending !== e.p) begin
                errors++;
                $display("FAIL %s step %0d pending got %b want %b", phase, e.step, pending, e.p);
            end
            if (request !== e.r) begin
                errors++;
                $display("FAIL %s step %0d request got %b want %b", phase, e.step, request, e.r);
            end
            if (stuck_alarm !== e.a) begin
                errors++;
                $display("FAIL %s step %0d stuck_alarm got %b want %b", phase, e.step, stuck_alarm, e.a);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        tick(4'b0000);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] bit_n, bit_s, bit_e, bit_w;
        logic       bounce [7];
        bit_n = 4'(1 << DIR_N);
        bit_s = 4'(1 << DIR_S);
        bit_e = 4'(1 << DIR_E);
        bit_w = 4'(1 << DIR_W);
        bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        btn_raw  = 4'b0000;
        ns_green = 1'b0;
        ew_green = 1'b0;
        do_reset();

        phase = "idle";
        repeat (20) tick(4'b0000);

        phase = "latency";
        btn_raw = bit_n;
        repeat (DB + 2) tick(4'b0000);
        tick(4'b0001);
        ns_green = 1'b1;
        tick(4'b0001);
        ns_green = 1'b0;
        tick(4'b0000);
        phase = "hold_no_retrigger";
        repeat (30) tick(4'b0000);
        btn_raw = 4'b0000;
        repeat (2) tick(4'b0000);
        btn_raw = bit_n;
        repeat (10) tick(4'b0000);
        btn_raw = 4'b0000;
        repeat (10) tick(4'b0000);
        do_reset();

        phase = "bounce";
        for (int i = 0; i < 7; i++) begin
            btn_raw = bounce[i] ? bit_e : 4'b0000;
            tick(4'b0000);
        end
        btn_raw = bit_e;
        repeat (6) tick(4'b0000);
        tick(4'b0100);
        btn_raw  = 4'b0000;
        ew_green = 1'b1;
        tick(4'b0100);
        ew_green = 1'b0;
        tick(4'b0000);
        repeat (8) tick(4'b0000);
        do_reset();

        phase = "ns_clear";
        btn_raw = bit_n | bit_s;
        repeat (6) tick(4'b0000);
        tick(4'b0011);
        btn_raw  = 4'b0000;
        ns_green = 1'b1;
        ew_green = 1'b1;
        repeat (2) tick(4'b0011);
        ew_green = 1'b0;
        repeat (8) tick(4'b0011);
        ns_green = 1'b0;
        tick(4'b0000);
        repeat (8) tick(4'b0000);
        do_reset();

        phase = "set_wins";
        btn_raw = bit_n;
        repeat (6) tick(4'b0000);
        tick(4'b0001);
        btn_raw = bit_s;
        repeat (5) tick(4'b0001);
        ns_green = 1'b1;
        tick(4'b0001);
        ns_green = 1'b0;
        tick(4'b0010);
        btn_raw  = 4'b0000;
        ns_green = 1'b1;
        tick(4'b0010);
        ns_green = 1'b0;
        tick(4'b0000);
        repeat (8) tick(4'b0000);
        do_reset();

        phase = "reset_mid_pulse";
        btn_raw = bit_e;
        repeat (6) tick(4'b0000);
        btn_raw = 4'b0000;
        do_reset();
        repeat (8) tick(4'b0000);

        phase = "stuck_alarm";
        btn_raw = bit_w;
        repeat (6) tick(4'b0000);
        tick(4'b1000);
        btn_raw = 4'b0000;
        repeat (MAXP - 1) tick(4'b1000);
        ew_green = 1'b1;
        tick(4'b1000);
        ew_green = 1'b0;
        tick(4'b0000);
        repeat (3) tick(4'b0000);
        phase = "final_reset";
        do_reset();
        tick(4'b0000);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
